// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one port of the BRAM main memory between two masters: the core's
// data interface (m0) and a secondary master such as DMA or a debug loader
// (m1). At most one access is issued per cycle. Read data, which the BRAM
// returns one cycle after the address, is routed back to the master that
// issued the read.
//
// Arbitration:
//   - a lone requester is always granted;
//   - on a tie, the master granted last cycle keeps the port if it holds lock
//     and has used fewer than MAX_BURST contested grants in a row;
//   - otherwise the master not granted most recently wins (round-robin).
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   mN_req/we/lock         request, write strobe, burst lock   (N = 0, 1)
//   mN_addr/wdata/be       byte address, write data, byte enables
//   mN_gnt                 combinational grant for this cycle
//   mN_rvalid/rdata        read response, one cycle after a read grant
//   mem_addr/wdata/be/we   memory request, driven by the granted master
//   mem_rdata              registered read data from memory
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_be,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_be,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Registered state
  logic             last;       // index of the most recently granted master
  logic             owner_v;    // a grant was issued last cycle (to 'last')
  logic [CNT_W-1:0] burst_cnt;  // consecutive contested grants to the owner
  logic             resp_v;     // read response due this cycle
  logic             resp_id;    // master that owns the pending response

  // Combinational arbitration results
  logic             gnt_v;
  logic             gnt_id;
  logic             hold;
  logic             sel_we;
  logic             sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_be;
  logic [CNT_W-1:0] burst_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    gnt_v  = 1'b0;
    gnt_id = 1'b0;

    // The previous owner may keep the port on a tie only while it still
    // requests with lock and has not exhausted its burst allowance.
    hold = owner_v
        && (last ? m1_req  : m0_req)
        && (last ? m1_lock : m0_lock)
        && (burst_cnt < CNT_W'(MAX_BURST));

    if (!rst) begin
      case ({m1_req, m0_req})
        2'b01:   begin gnt_v = 1'b1; gnt_id = 1'b0; end
        2'b10:   begin gnt_v = 1'b1; gnt_id = 1'b1; end
        2'b11:   begin gnt_v = 1'b1; gnt_id = hold ? last : ~last; end
        default: begin gnt_v = 1'b0; gnt_id = 1'b0; end
      endcase
    end
  end

  assign m0_gnt = gnt_v & ~gnt_id;
  assign m1_gnt = gnt_v &  gnt_id;

  // Fields of the granted master
  assign sel_we    = gnt_id ? m1_we    : m0_we;
  assign sel_lock  = gnt_id ? m1_lock  : m0_lock;
  assign sel_addr  = gnt_id ? m1_addr  : m0_addr;
  assign sel_wdata = gnt_id ? m1_wdata : m0_wdata;
  assign sel_be    = gnt_id ? m1_be    : m0_be;

  // ---------------------------------------------------------------------------
  // Memory request: quiet (all zero) whenever nothing is granted
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_we    = 1'b0;
    if (gnt_v) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      mem_we    = sel_we;
      mem_be    = sel_we ? sel_be : 4'b0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst counter: only contested, locked grants count. Any grant taken
  // without contention, without lock, or by a new owner restarts the count.
  // A contested grant to the same owner implies hold was true, so the count
  // never runs past MAX_BURST.
  // ---------------------------------------------------------------------------
  always_comb begin
    burst_nxt = '0;
    if (gnt_v && m0_req && m1_req && sel_lock) begin
      if (owner_v && (gnt_id == last))
        burst_nxt = burst_cnt + CNT_W'(1);
      else
        burst_nxt = CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      last      <= 1'b1;  // m0 wins the first tie after reset
      owner_v   <= 1'b0;
      burst_cnt <= '0;
      resp_v    <= 1'b0;
      resp_id   <= 1'b0;
    end else begin
      owner_v   <= gnt_v;
      burst_cnt <= burst_nxt;
      resp_v    <= gnt_v & ~sel_we;
      if (gnt_v) begin
        last    <= gnt_id;
        resp_id <= gnt_id;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read response: gated by rst so a read granted just before reset is dropped
  // ---------------------------------------------------------------------------
  assign m0_rvalid = resp_v & ~resp_id & ~rst;
  assign m1_rvalid = resp_v &  resp_id & ~rst;
  assign m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A small BRAM model (one-cycle
// registered read, byte-enabled write) sits on the memory port; its initial
// image holds 32'hA500_0000 | word_index in every word. Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int ADDR_W = 13;

  logic              clk;
  logic              rst;
  logic              m0_req, m0_we, m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic [3:0]        m0_be;
  logic              m0_gnt, m0_rvalid;
  logic [31:0]       m0_rdata;
  logic              m1_req, m1_we, m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic [3:0]        m1_be;
  logic              m1_gnt, m1_rvalid;
  logic [31:0]       m1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_lock   (m0_lock),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_be     (m0_be),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_be     (m1_be),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // BRAM model: 2048 words, read data registered, byte-enabled writes
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:2047];
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    // NOTE: memory contents are never cleared by reset; the image is loaded
    // once on the first edge and survives later resets.
    if (!loaded) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      loaded <= 1'b1;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= mem[mem_addr[12:2]];
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic lock,
                          input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    m0_req = req; m0_we = we; m0_lock = lock;
    m0_addr = addr; m0_wdata = wdata; m0_be = be;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic lock,
                          input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    m1_req = req; m1_we = we; m1_lock = lock;
    m1_addr = addr; m1_wdata = wdata; m1_be = be;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k;

    rst = 1'b1;
    drive_m0(0, 0, 0, '0, '0, '0);
    drive_m1(0, 0, 0, '0, '0, '0);
    next_cycle;

    // Reset held with both masters requesting: nothing may be granted.
    drive_m0(1, 1, 0, 13'h010, 32'h1111_1111, 4'hF);
    drive_m1(1, 0, 1, 13'h020, 32'h0, 4'h0);
    @(negedge clk);
    check_bit("rst_m0_gnt", m0_gnt, 1'b0);
    check_bit("rst_m1_gnt", m1_gnt, 1'b0);
    check_bit("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_be", {28'b0, mem_be}, 32'h0);
    check_bit("rst_m0_rvalid", m0_rvalid, 1'b0);
    check_bit("rst_m1_rvalid", m1_rvalid, 1'b0);
    check("rst_m0_rdata", m0_rdata, 32'h0);
    check("rst_m1_rdata", m1_rdata, 32'h0);
    next_cycle;
    rst = 1'b0;

    // m0 single read of 0x010 (word 4).
    drive_m0(1, 0, 0, 13'h010, 32'h0, 4'h0);
    drive_m1(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_bit("rd0_m0_gnt", m0_gnt, 1'b1);
    check_bit("rd0_m1_gnt", m1_gnt, 1'b0);
    check("rd0_mem_addr", {19'b0, mem_addr}, 32'h010);
    check_bit("rd0_mem_we", mem_we, 1'b0);
    check("rd0_mem_be", {28'b0, mem_be}, 32'h0);
    next_cycle;
    drive_m0(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_bit("rd0_m0_rvalid", m0_rvalid, 1'b1);
    check("rd0_m0_rdata", m0_rdata, 32'hA500_0004);
    check_bit("rd0_m1_rvalid", m1_rvalid, 1'b0);
    check("rd0_m1_rdata", m1_rdata, 32'h0);
    check("idle_mem_be", {28'b0, mem_be}, 32'h0);
    check("idle_mem_addr", {19'b0, mem_addr}, 32'h0);
    next_cycle;

    // m1 single read of 0x100 (word 64).
    drive_m1(1, 0, 0, 13'h100, 32'h0, 4'h0);
    @(negedge clk);
    check_bit("rd1_m1_gnt", m1_gnt, 1'b1);
    check_bit("rd1_m0_gnt", m0_gnt, 1'b0);
    next_cycle;
    drive_m1(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_bit("rd1_m1_rvalid", m1_rvalid, 1'b1);
    check("rd1_m1_rdata", m1_rdata, 32'hA500_0040);
    check("rd1_m0_rdata", m0_rdata, 32'h0);
    next_cycle;

    // Both masters reading back to back without lock: m0, m1, m0, m1.
    drive_m0(1, 0, 0, 13'h040, 32'h0, 4'h0);
    drive_m1(1, 0, 0, 13'h080, 32'h0, 4'h0);
    @(negedge clk);
    check_bit("rr_c0_m0_gnt", m0_gnt, 1'b1);
    check_bit("rr_c0_m1_gnt", m1_gnt, 1'b0);
    check("rr_c0_addr", {19'b0, mem_addr}, 32'h040);
    next_cycle;
    drive_m0(1, 0, 0, 13'h044, 32'h0, 4'h0);
    @(negedge clk);
    check_bit("rr_c1_m1_gnt", m1_gnt, 1'b1);
    check_bit("rr_c1_m0_gnt", m0_gnt, 1'b0);
    check("rr_c1_addr", {19'b0, mem_addr}, 32'h080);
    check_bit("rr_c1_m0_rvalid", m0_rvalid, 1'b1);
    check("rr_c1_m0_rdata", m0_rdata, 32'hA500_0010);
    check_bit("rr_c1_m1_rvalid", m1_rvalid, 1'b0);
    next_cycle;
    drive_m1(1, 0, 0, 13'h084, 32'h0, 4'h0);
    @(negedge clk);
    check_bit("rr_c2_m0_gnt", m0_gnt, 1'b1);
    check("rr_c2_addr", {19'b0, mem_addr}, 32'h044);
    check_bit("rr_c2_m1_rvalid", m1_rvalid, 1'b1);
    check("rr_c2_m1_rdata", m1_rdata, 32'hA500_0020);
    check("rr_c2_m0_rdata", m0_rdata, 32'h0);
    next_cycle;
    drive_m0(1, 0, 0, 13'h048, 32'h0, 4'h0);
    @(negedge clk);
    check_bit("rr_c3_m1_gnt", m1_gnt, 1'b1);
    check("rr_c3_addr", {19'b0, mem_addr}, 32'h084);
    check("rr_c3_m0_rdata", m0_rdata, 32'hA500_0011);
    next_cycle;
    drive_m0(0, 0, 0, '0, '0, '0);
    drive_m1(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_bit("rr_c4_m1_rvalid", m1_rvalid, 1'b1);
    check("rr_c4_m1_rdata", m1_rdata, 32'hA500_0021);
    check_bit("rr_c4_m0_rvalid", m0_rvalid, 1'b0);
    next_cycle;

    // Partial write by m0, then read back by m1 and by m0.
    drive_m0(1, 1, 0, 13'h020, 32'hDEAD_BEEF, 4'b0011);
    @(negedge clk);
    check_bit("wr_m0_gnt", m0_gnt, 1'b1);
    check_bit("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_be", {28'b0, mem_be}, 32'h3);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_mem_addr", {19'b0, mem_addr}, 32'h020);
    next_cycle;
    drive_m0(0, 0, 0, '0, '0, '0);
    drive_m1(1, 0, 0, 13'h020, 32'h0, 4'h0);
    @(negedge clk);
    check_bit("wrrd_m1_gnt", m1_gnt, 1'b1);
    check_bit("wrrd_mem_we", mem_we, 1'b0);
    check("wrrd_mem_be", {28'b0, mem_be}, 32'h0);
    check_bit("wr_no_rvalid", m0_rvalid, 1'b0);
    next_cycle;
    drive_m1(0, 0, 0, '0, '0, '0);
    drive_m0(1, 0, 0, 13'h020, 32'h0, 4'h0);
    @(negedge clk);
    check_bit("wrrd_m1_rvalid", m1_rvalid, 1'b1);
    check("wrrd_m1_rdata", m1_rdata, 32'hA500_BEEF);
    check_bit("wrrd_m0_gnt", m0_gnt, 1'b1);
    next_cycle;
    drive_m0(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check("wrrd_m0_rdata", m0_rdata, 32'hA500_BEEF);
    check_bit("wrrd_c3_m1_rvalid", m1_rvalid, 1'b0);
    next_cycle;

    // m1 locked burst of 8 writes while m0 waits with one read of 0x000:
    // m1 takes 4 grants, m0 one, then m1 finishes its last 4 writes.
    for (int b = 0; b < 9; b++) begin
      k = (b < 4) ? b : b - 1;
      drive_m1(1, 1, (k != 7), 13'(32'h200 + 4 * k), 32'hC0DE_0000 + 32'(k), 4'hF);
      if (b <= 4) drive_m0(1, 0, 0, 13'h000, 32'h0, 4'h0);
      else        drive_m0(0, 0, 0, '0, '0, '0);
      @(negedge clk);
      check_bit($sformatf("burst_b%0d_m1_gnt", b), m1_gnt, (b != 4));
      check_bit($sformatf("burst_b%0d_m0_gnt", b), m0_gnt, (b == 4));
      if (b == 1) check_bit("burst_wr_no_rvalid", m1_rvalid, 1'b0);
      if (b == 4) check("burst_m0_rd_be", {28'b0, mem_be}, 32'h0);
      if (b == 5) begin
        check_bit("burst_m0_rvalid", m0_rvalid, 1'b1);
        check("burst_m0_rdata", m0_rdata, 32'hA500_0000);
      end
      next_cycle;
    end
    drive_m1(0, 0, 0, '0, '0, '0);

    // Pipelined readback of the burst by m1: one read and one rvalid per cycle.
    for (int r = 0; r < 9; r++) begin
      if (r < 8) drive_m1(1, 0, 0, 13'(32'h200 + 4 * r), 32'h0, 4'h0);
      else       drive_m1(0, 0, 0, '0, '0, '0);
      @(negedge clk);
      if (r < 8) check_bit($sformatf("rb_%0d_m1_gnt", r), m1_gnt, 1'b1);
      if (r > 0) begin
        check_bit($sformatf("rb_%0d_m1_rvalid", r), m1_rvalid, 1'b1);
        check($sformatf("rb_%0d_m1_rdata", r), m1_rdata, 32'hC0DE_0000 + 32'(r - 1));
      end
      next_cycle;
    end

    // m1 locked read granted, then reset in the following cycle: no rvalid.
    drive_m1(1, 0, 1, 13'h100, 32'h0, 4'h0);
    @(negedge clk);
    check_bit("rstrd_m1_gnt", m1_gnt, 1'b1);
    next_cycle;
    rst = 1'b1;
    drive_m0(1, 1, 0, 13'h030, 32'hFFFF_FFFF, 4'hF);
    drive_m1(1, 0, 1, 13'h008, 32'h0, 4'h0);
    @(negedge clk);
    check_bit("rstrd_m1_rvalid", m1_rvalid, 1'b0);
    check("rstrd_m1_rdata", m1_rdata, 32'h0);
    check_bit("rstrd_m0_gnt", m0_gnt, 1'b0);
    check_bit("rstrd_m1_gnt", m1_gnt, 1'b0);
    check_bit("rstrd_mem_we", mem_we, 1'b0);
    check("rstrd_mem_be", {28'b0, mem_be}, 32'h0);
    next_cycle;
    rst = 1'b0;
    drive_m0(1, 0, 0, 13'h004, 32'h0, 4'h0);
    @(negedge clk);
    check_bit("post_rst_m0_gnt", m0_gnt, 1'b1);
    check_bit("post_rst_m1_gnt", m1_gnt, 1'b0);
    check_bit("post_rst_m1_rvalid", m1_rvalid, 1'b0);
    next_cycle;
    drive_m0(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_bit("post_rst_m1_gnt2", m1_gnt, 1'b1);
    check("post_rst_m0_rdata", m0_rdata, 32'hA500_0001);
    next_cycle;
    drive_m1(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_bit("post_rst_m1_rvalid2", m1_rvalid, 1'b1);
    check("post_rst_m1_rdata", m1_rdata, 32'hA500_0002);
    check_bit("post_rst_idle_we", mem_we, 1'b0);
    next_cycle;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
